// File: rtl/lcd_cmd_queue.sv
// -----------------------------------------------------------------------------
// lcd_cmd_queue
//
// Purpose:
//   Command queue between the Nios PIO LCD-control word and the hx8352
//   controller step/busy interface. CPU-written {cmd,data} words are captured
//   on every toggle of pio_word[31] and buffered in a FIFO. They are then issued
//   one at a time with a step pulse, followed by a two-phase busy handshake
//   (wait for busy high, then wait for busy low). Each busy phase is guarded by
//   a timeout. Overflow and timeout are sticky status bits that are cleared by
//   clear_err.
//
// Optional feature (compile-time macro LCD_CMD_QUEUE_REPEAT_EN):
//   Each entry also stores rep = pio_word[27:20]. The entry is issued rep+1
//   times before it is popped, which allows pixel fills. A timeout pops the
//   entry whatever repeats remain. When the macro is undefined, bits [27:20]
//   are ignored and each entry is issued exactly once.
//
// Parameters:
//   DATA_W        data field width, taken from pio_word[DATA_W-1:0]
//   CMD_W         cmd field width, taken from pio_word[16 +: CMD_W]
//   DEPTH         FIFO entries (power of 2, >= 2)
//   BUSY_TIMEOUT  maximum number of cycles spent in each busy-wait phase
//
// Ports:
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   pio_word   in   [31] step toggle, [16+:CMD_W] cmd, [DATA_W-1:0] data
//   init_done  in   controller init complete; no new issue while low
//   lcd_busy   in   controller busy
//   clear_err  in   single-cycle pulse that clears overflow and timeout
//   lcd_step   out  single-cycle issue pulse to the controller
//   lcd_cmd    out  command presented with lcd_step and held afterwards
//   lcd_data   out  data presented with lcd_step and held afterwards
//   level      out  current FIFO occupancy
//   full       out  FIFO full
//   empty      out  FIFO empty
//   overflow   out  sticky: a push was attempted while the FIFO was full
//   timeout    out  sticky: a busy handshake timed out
// -----------------------------------------------------------------------------
module lcd_cmd_queue #(
    parameter int DATA_W       = 16,
    parameter int CMD_W        = 4,
    parameter int DEPTH        = 16,
    parameter int BUSY_TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [31:0]              pio_word,
    input  logic                     init_done,
    input  logic                     lcd_busy,
    input  logic                     clear_err,
    output logic                     lcd_step,
    output logic [CMD_W-1:0]         lcd_cmd,
    output logic [DATA_W-1:0]        lcd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    output logic                     timeout
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int TW = $clog2(BUSY_TIMEOUT + 1);
`ifdef LCD_CMD_QUEUE_REPEAT_EN
    localparam int REP_W = 8;
`else
    localparam int REP_W = 0;
`endif
    localparam int ENTRY_W = REP_W + CMD_W + DATA_W;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_HI,
        S_WAIT_LO,
        S_DONE
    } state_t;

    // FIFO storage and bookkeeping
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [LW-1:0]      count_q;
    logic [LW-1:0]      count_d;
    logic               step_q;

    // Issue FSM state and registered outputs
    state_t             state_q;
    logic [TW-1:0]      timer_q;
    logic               lcd_step_q;
    logic [CMD_W-1:0]   lcd_cmd_q;
    logic [DATA_W-1:0]  lcd_data_q;
    logic               overflow_q;
    logic               timeout_q;
`ifdef LCD_CMD_QUEUE_REPEAT_EN
    logic [7:0]         rep_cnt_q;
    logic               first_q;    // next issue of the head entry is its first
`endif

    // Per-cycle events
    logic push_req;
    logic push_acc;
    logic pop;
    logic done_pop;
    logic tmo_hit;
    logic tmo_evt;
    logic ovf_evt;
    logic unused_pio;

    // Any bit of the PIO word not mapped to a field is intentionally ignored.
    assign unused_pio = ^pio_word;

`ifdef LCD_CMD_QUEUE_REPEAT_EN
    assign wr_entry = {pio_word[27:20], pio_word[16 +: CMD_W], pio_word[DATA_W-1:0]};
`else
    assign wr_entry = {pio_word[16 +: CMD_W], pio_word[DATA_W-1:0]};
`endif

    assign full  = (count_q == LW'(DEPTH));
    assign empty = (count_q == '0);
    assign level = count_q;

    // Either edge of the toggle bit is a new word.
    assign push_req = pio_word[31] ^ step_q;

    assign tmo_hit = (timer_q == TW'(BUSY_TIMEOUT - 1));

    // A busy phase that ends in the same cycle as the limit is reached
    // counts as completed, not timed out.
    always_comb begin
        tmo_evt = 1'b0;
        if (state_q == S_WAIT_HI && !lcd_busy && tmo_hit) begin
            tmo_evt = 1'b1;
        end
        if (state_q == S_WAIT_LO && lcd_busy && tmo_hit) begin
            tmo_evt = 1'b1;
        end
    end

`ifdef LCD_CMD_QUEUE_REPEAT_EN
    assign done_pop = (state_q == S_DONE) && (rep_cnt_q == 8'd0);
`else
    assign done_pop = (state_q == S_DONE);
`endif

    assign pop = done_pop || tmo_evt;

    // A pop in the same cycle frees a slot, so a push while full is accepted.
    assign push_acc = push_req && (!full || pop);
    assign ovf_evt  = push_req && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push_acc && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push_acc) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage array without reset so it maps onto RAM. The head is captured
    // into the lcd_cmd/lcd_data output registers when the entry is issued.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

    assign head_entry = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            step_q  <= pio_word[31];
            count_q <= count_d;
            if (push_acc) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            // clear_err wins; a set event in the same cycle is lost.
            if (clear_err) begin
                overflow_q <= 1'b0;
                timeout_q  <= 1'b0;
            end else begin
                if (ovf_evt) begin
                    overflow_q <= 1'b1;
                end
                if (tmo_evt) begin
                    timeout_q <= 1'b1;
                end
            end
        end
    end

    // Issue FSM. The head stays in the FIFO until its last issue completes
    // (DONE) or a timeout occurs. The FIFO block above performs the pop itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            lcd_step_q <= 1'b0;
            lcd_cmd_q  <= '0;
            lcd_data_q <= '0;
`ifdef LCD_CMD_QUEUE_REPEAT_EN
            rep_cnt_q  <= 8'd0;
            first_q    <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!empty && init_done && !lcd_busy) begin
                        state_q    <= S_ISSUE;
                        lcd_step_q <= 1'b1;
                        lcd_cmd_q  <= head_entry[DATA_W +: CMD_W];
                        lcd_data_q <= head_entry[DATA_W-1:0];
`ifdef LCD_CMD_QUEUE_REPEAT_EN
                        if (first_q) begin
                            rep_cnt_q <= head_entry[ENTRY_W-1 -: 8];
                            first_q   <= 1'b0;
                        end
`endif
                    end
                end
                S_ISSUE: begin
                    lcd_step_q <= 1'b0;
                    timer_q    <= '0;
                    state_q    <= S_WAIT_HI;
                end
                S_WAIT_HI: begin
                    if (lcd_busy) begin
                        timer_q <= '0;
                        state_q <= S_WAIT_LO;
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
`ifdef LCD_CMD_QUEUE_REPEAT_EN
                        first_q <= 1'b1;
`endif
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_WAIT_LO: begin
                    if (!lcd_busy) begin
                        state_q <= S_DONE;
                    end else if (tmo_hit) begin
                        state_q <= S_IDLE;
`ifdef LCD_CMD_QUEUE_REPEAT_EN
                        first_q <= 1'b1;
`endif
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
`ifdef LCD_CMD_QUEUE_REPEAT_EN
                    // Remaining repeats: back to IDLE without popping so the
                    // same head entry is issued again.
                    if (rep_cnt_q != 8'd0) begin
                        rep_cnt_q <= rep_cnt_q - 8'd1;
                    end else begin
                        first_q <= 1'b1;
                    end
`endif
                end
                default: begin
                    state_q    <= S_IDLE;
                    lcd_step_q <= 1'b0;
                end
            endcase
        end
    end

    assign lcd_step = lcd_step_q;
    assign lcd_cmd  = lcd_cmd_q;
    assign lcd_data = lcd_data_q;
    assign overflow = overflow_q;
    assign timeout  = timeout_q;

endmodule

// File: tb/tb_lcd_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_lcd_cmd_queue
//
// Directed, self-checking bench for lcd_cmd_queue. A small controller model
// raises busy for 5 cycles, starting one cycle after each step. The same model
// logs every issued {cmd,data} pair. The log is compared against a queue of
// expected words built from the stimulus.
// -----------------------------------------------------------------------------
module tb_lcd_cmd_queue;

    localparam int BT    = 64;
    localparam int DEPTH = 16;
`ifdef LCD_CMD_QUEUE_REPEAT_EN
    localparam int REPS = 4;
`else
    localparam int REPS = 1;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pio_word;
    logic        init_done;
    logic        lcd_busy;
    logic        clear_err;
    logic        lcd_step;
    logic [3:0]  lcd_cmd;
    logic [15:0] lcd_data;
    logic [4:0]  level;
    logic        full;
    logic        empty;
    logic        overflow;
    logic        timeout;

    logic        busy_mode;   // 1: controller model drives busy, 0: force_busy
    logic        force_busy;
    logic        model_busy;
    logic        tgl;
    int          busy_left;
    int          step_cnt;
    int          checks;
    int          failures;
    logic [19:0] log_q [$];
    logic [19:0] exp_q [$];

    typedef struct {
        bit          do_push;
        logic [3:0]  cmd;
        logic [15:0] data;
        bit          clr;
        int          exp_level;
        bit          exp_full;
        bit          exp_ovf;
        bit          exp_acc;
    } vec_t;

    vec_t vec2 [4];
    vec_t vec3 [20];

    assign lcd_busy = busy_mode ? model_busy : force_busy;

    lcd_cmd_queue #(
        .DATA_W(16),
        .CMD_W(4),
        .DEPTH(DEPTH),
        .BUSY_TIMEOUT(BT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pio_word(pio_word),
        .init_done(init_done),
        .lcd_busy(lcd_busy),
        .clear_err(clear_err),
        .lcd_step(lcd_step),
        .lcd_cmd(lcd_cmd),
        .lcd_data(lcd_data),
        .level(level),
        .full(full),
        .empty(empty),
        .overflow(overflow),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    // Controller model and step logger, sampled 2 ns after each rising edge.
    always begin
        @(posedge clk);
        #2;
        if (busy_left > 0) begin
            model_busy = 1'b1;
            busy_left  = busy_left - 1;
        end else begin
            model_busy = 1'b0;
        end
        if (lcd_step) begin
            step_cnt = step_cnt + 1;
            log_q.push_back({lcd_cmd, lcd_data});
            if (busy_mode) begin
                busy_left = 5;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic push(input logic [3:0] c, input logic [15:0] d, input logic [7:0] r);
        tgl      = ~tgl;
        pio_word = {tgl, 3'b000, r, c, d};
        tick();
    endtask

    task automatic apply(input vec_t v, input string tag);
        if (v.do_push) begin
            tgl      = ~tgl;
            pio_word = {tgl, 3'b000, 8'h00, v.cmd, v.data};
            if (v.exp_acc) begin
                exp_q.push_back({v.cmd, v.data});
            end
        end
        clear_err = v.clr;
        tick();
        clear_err = 1'b0;
        chk({tag, "_level"}, 32'(level), 32'(v.exp_level));
        chk({tag, "_full"}, 32'(full), 32'(v.exp_full));
        chk({tag, "_empty"}, 32'(empty), 32'(v.exp_level == 0));
        chk({tag, "_ovf"}, 32'(overflow), 32'(v.exp_ovf));
    endtask

    task automatic wait_empty(input int max, input string tag);
        int n = 0;
        while (!empty && n < max) begin
            tick();
            n++;
        end
        checks = checks + 1;
        if (!empty) begin
            failures = failures + 1;
            $display("FAIL %s: not drained after %0d cycles, empty=%0b, expected 1", tag, max, empty);
        end else begin
            $display("ok   %s: drained after %0d cycles", tag, n);
        end
    endtask

    task automatic verify_log(input string tag);
        chk({tag, "_count"}, 32'(log_q.size()), 32'(exp_q.size()));
        while (log_q.size() > 0 && exp_q.size() > 0) begin
            chk({tag, "_word"}, 32'(log_q.pop_front()), 32'(exp_q.pop_front()));
        end
        log_q.delete();
        exp_q.delete();
    endtask

    // Stops at the cycle in which the FSM is in DONE.
    task automatic handshake_to_done(input string tag);
        int n = 0;
        while (!lcd_step && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_step_seen"}, 32'(lcd_step), 32'd1);
        force_busy = 1'b1;
        tick();
        tick();
        force_busy = 1'b0;
        tick();
    endtask

    initial begin
        int sc;

        // Vector tables
        for (int i = 0; i < 4; i++) begin
            vec2[i] = '{1'b1, 4'(i + 3), 16'h1000 + 16'(i), 1'b0, i + 1, 1'b0, 1'b0, 1'b1};
        end
        for (int i = 0; i < 16; i++) begin
            vec3[i] = '{1'b1, 4'(i), 16'h3000 + 16'(i), 1'b0, i + 1, (i == 15), 1'b0, 1'b1};
        end
        vec3[16] = '{1'b1, 4'hE, 16'hDEAD, 1'b0, 16, 1'b1, 1'b1, 1'b0};
        vec3[17] = '{1'b1, 4'hE, 16'hBEEF, 1'b1, 16, 1'b1, 1'b0, 1'b0};
        vec3[18] = '{1'b1, 4'hF, 16'hF00D, 1'b0, 16, 1'b1, 1'b1, 1'b0};
        vec3[19] = '{1'b0, 4'h0, 16'h0000, 1'b1, 16, 1'b1, 1'b0, 1'b0};

        checks     = 0;
        failures   = 0;
        step_cnt   = 0;
        busy_left  = 0;
        model_busy = 1'b0;
        busy_mode  = 1'b1;
        force_busy = 1'b0;
        tgl        = 1'b0;
        rst_n      = 1'b0;
        pio_word   = 32'h0;
        init_done  = 1'b0;
        clear_err  = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        chk("rst_tmo", 32'(timeout), 32'd0);
        chk("rst_step", 32'(lcd_step), 32'd0);
        chk("rst_cmd", 32'(lcd_cmd), 32'd0);
        chk("rst_data", 32'(lcd_data), 32'd0);
        rst_n = 1'b1;
        tick();

        // 1: single word, latency, one pulse
        init_done = 1'b1;
        push(4'h2, 16'hA55A, 8'h00);
        exp_q.push_back({4'h2, 16'hA55A});
        chk("t1_level_after_push", 32'(level), 32'd1);
        chk("t1_no_step_yet", 32'(lcd_step), 32'd0);
        tick();
        chk("t1_step", 32'(lcd_step), 32'd1);
        chk("t1_cmd", 32'(lcd_cmd), 32'h2);
        chk("t1_data", 32'(lcd_data), 32'hA55A);
        tick();
        chk("t1_step_one_cycle", 32'(lcd_step), 32'd0);
        chk("t1_data_held", 32'(lcd_data), 32'hA55A);
        wait_empty(40, "t1_drain");
        chk("t1_level_end", 32'(level), 32'd0);
        chk("t1_steps", 32'(step_cnt), 32'd1);
        verify_log("t1_log");

        // 2: four back-to-back pushes held off by init_done
        init_done = 1'b0;
        sc = step_cnt;
        for (int i = 0; i < 4; i++) begin
            apply(vec2[i], $sformatf("t2_v%0d", i));
        end
        repeat (5) tick();
        chk("t2_no_step", 32'(step_cnt), 32'(sc));
        init_done = 1'b1;
        wait_empty(200, "t2_drain");
        chk("t2_steps", 32'(step_cnt - sc), 32'd4);
        verify_log("t2_log");

        // 3: busy stuck high, fill past full, overflow and clear priority
        busy_mode  = 1'b0;
        force_busy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            apply(vec3[i], $sformatf("t3_v%0d", i));
        end
        force_busy = 1'b0;
        busy_mode  = 1'b1;
        wait_empty(400, "t3_drain");
        verify_log("t3_log");

        // 4: busy never rises, timeout after BT cycles in WAIT_HI
        busy_mode  = 1'b0;
        force_busy = 1'b0;
        push(4'h9, 16'h0BAD, 8'h00);
        exp_q.push_back({4'h9, 16'h0BAD});
        chk("t4_level", 32'(level), 32'd1);
        repeat (BT + 1) tick();
        chk("t4_tmo_not_early", 32'(timeout), 32'd0);
        chk("t4_level_held", 32'(level), 32'd1);
        tick();
        chk("t4_tmo", 32'(timeout), 32'd1);
        chk("t4_empty", 32'(empty), 32'd1);
        verify_log("t4_log");
        clear_err = 1'b1;
        tick();
        clear_err = 1'b0;
        chk("t4_tmo_cleared", 32'(timeout), 32'd0);

        // 5a: push and pop in the same cycle at level 3
        init_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push(4'h5, 16'h5000 + 16'(i), 8'h00);
            exp_q.push_back({4'h5, 16'h5000 + 16'(i)});
        end
        chk("t5a_level_pre", 32'(level), 32'd3);
        init_done = 1'b1;
        handshake_to_done("t5a");
        chk("t5a_level_done", 32'(level), 32'd3);
        init_done = 1'b0;
        push(4'h6, 16'h6000, 8'h00);
        exp_q.push_back({4'h6, 16'h6000});
        chk("t5a_level_pushpop", 32'(level), 32'd3);

        // 5b: push and pop in the same cycle while full
        for (int i = 0; i < 13; i++) begin
            push(4'h7, 16'h7000 + 16'(i), 8'h00);
            exp_q.push_back({4'h7, 16'h7000 + 16'(i)});
        end
        chk("t5b_full_pre", 32'(full), 32'd1);
        init_done = 1'b1;
        handshake_to_done("t5b");
        init_done = 1'b0;
        push(4'h8, 16'h8000, 8'h00);
        exp_q.push_back({4'h8, 16'h8000});
        chk("t5b_level_pushpop", 32'(level), 32'd16);
        chk("t5b_full", 32'(full), 32'd1);
        chk("t5b_no_ovf", 32'(overflow), 32'd0);
        busy_mode = 1'b1;
        init_done = 1'b1;
        wait_empty(400, "t5b_drain");
        verify_log("t5b_log");

        // 5c: 40 words through the pointers, in order
        for (int i = 0; i < 40; i++) begin
            push(4'(i), 16'hC000 + 16'(i), 8'h00);
            exp_q.push_back({4'(i), 16'hC000 + 16'(i)});
            repeat (11) tick();
        end
        wait_empty(100, "t5c_drain");
        chk("t5c_no_ovf", 32'(overflow), 32'd0);
        verify_log("t5c_log");

        // 6: repeat count field
        sc = step_cnt;
        push(4'hA, 16'h1234, 8'd3);
        for (int i = 0; i < REPS; i++) begin
            exp_q.push_back({4'hA, 16'h1234});
        end
        wait_empty(200, "t6_drain");
        chk("t6_steps", 32'(step_cnt - sc), 32'(REPS));
        verify_log("t6_log");

        // 7: reset in the middle of an issue aborts everything
        push(4'h3, 16'h3333, 8'h00);
        push(4'h4, 16'h4444, 8'h00);
        begin
            int n = 0;
            while (!lcd_step && n < 20) begin
                tick();
                n++;
            end
        end
        chk("t7_step_seen", 32'(lcd_step), 32'd1);
        sc       = step_cnt;
        rst_n    = 1'b0;
        pio_word = 32'h0;
        tgl      = 1'b0;
        #1;
        chk("t7_rst_level", 32'(level), 32'd0);
        chk("t7_rst_step", 32'(lcd_step), 32'd0);
        chk("t7_rst_data", 32'(lcd_data), 32'd0);
        tick();
        rst_n = 1'b1;
        repeat (20) tick();
        chk("t7_no_step_after", 32'(step_cnt), 32'(sc));
        chk("t7_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
